// File: rtl/apb_slave_pkg.sv
// ============================================================================
// Module      : apb_slave_pkg
// Description : Shared types, constants and the address-error helper for the
//               APB3 slave register file.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package apb_slave_pkg;

    // Bus-side transfer state
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    // Wait counter width: covers WAIT_CYCLES up to 15
    localparam int WAIT_CNT_W = 4;

    // Flags a byte address that is not word aligned or lies past the last word.
    // The address arrives zero-extended to 64 bits so one function serves every
    // ADDR_W. With lsb==0 the alignment mask is empty, so byte-wide buses only
    // get the range check.
    function automatic logic addr_err(input logic [63:0] addr,
                                      input int          lsb,
                                      input int          depth);
        logic [63:0] mask;
        logic [63:0] word_idx;
        mask     = (64'd1 << lsb) - 64'd1;
        word_idx = addr >> lsb;
        return ((addr & mask) != 64'd0) || (word_idx >= 64'(depth));
    endfunction

endpackage

`default_nettype wire

// File: rtl/apb_slave_mem.sv
// ============================================================================
// Module      : apb_slave_mem
// Description : DEPTH x DATA_W word storage with synchronous clear, per-byte
//               write enable and asynchronous read.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module apb_slave_mem #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int IDX_W  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [DATA_W/8-1:0] be,
    input  logic [IDX_W-1:0]    idx,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   rdata
);

    localparam int NBYTES = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              in_range;

    // Guards non-power-of-two depths where idx can name a missing word
    assign in_range = ({1'b0, idx} < (IDX_W + 1)'(DEPTH));

    // Clear every word on reset; otherwise write the enabled bytes of one word
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we && in_range) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (be[b]) begin
                    mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    assign rdata = in_range ? mem[idx] : '0;

endmodule

`default_nettype wire

// File: rtl/apb_slave_regfile.sv
// ============================================================================
// Module      : apb_slave_regfile
// Description : APB3 slave word-addressed register file with programmable
//               wait states and PSLVERR on misaligned / out-of-range access.
//               Optional macro APB_SLAVE_PSTRB_EN adds APB4 byte strobes
//               (port Pstrb); without it every write updates the full word.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module apb_slave_regfile
    import apb_slave_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 16,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                Pclk,
    input  logic                Preset,
    input  logic [ADDR_W-1:0]   Paddr,
    input  logic                Psel,
    input  logic                Penable,
    input  logic                Pwrite,
    input  logic [DATA_W-1:0]   Pwdata,
`ifdef APB_SLAVE_PSTRB_EN
    input  logic [DATA_W/8-1:0] Pstrb,
`endif
    output logic [DATA_W-1:0]   Prdata,
    output logic                Pready,
    output logic                Pslverr
);

    localparam int LSB   = $clog2(DATA_W / 8);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t                  state;
    logic [WAIT_CNT_W-1:0]   cnt;
    logic                    err;
    logic                    done;
    logic                    mem_we;
    logic [DATA_W/8-1:0]     mem_be;
    logic [IDX_W-1:0]        mem_idx;
    logic [DATA_W-1:0]       mem_rdata;

    // Address decode: only the bits that select an implemented word reach the
    // storage; anything beyond DEPTH is caught by err and never written/read.
    assign err     = addr_err(64'(Paddr), LSB, DEPTH);
    assign mem_idx = Paddr[LSB +: IDX_W];

`ifdef APB_SLAVE_PSTRB_EN
    assign mem_be = Pstrb;
`else
    assign mem_be = '1;
`endif

    // Transfer completes once the wait count has drained; reset masks it so
    // the bus sees no response while Preset is high.
    assign done    = (state == ACCESS) && Psel && Penable && (cnt == '0) && !Preset;
    assign mem_we  = done && Pwrite && !err;

    assign Pready  = done;
    assign Pslverr = done && err;
    assign Prdata  = (done && !Pwrite && !err) ? mem_rdata : '0;

    // Transfer FSM with wait-state counter
    always_ff @(posedge Pclk) begin
        if (Preset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Psel && !Penable) begin
                        state <= ACCESS;
                        cnt   <= WAIT_CNT_W'(WAIT_CYCLES);
                    end
                end
                ACCESS: begin
                    if (!Psel) begin
                        // Master abandoned the transfer; nothing is written
                        state <= IDLE;
                    end else if (Penable) begin
                        if (cnt != '0) begin
                            cnt <= cnt - 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    apb_slave_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_mem (
        .clk    (Pclk),
        .rst    (Preset),
        .we     (mem_we),
        .be     (mem_be),
        .idx    (mem_idx),
        .wdata  (Pwdata),
        .rdata  (mem_rdata)
    );

endmodule

`default_nettype wire

// File: tb/tb_apb_slave_regfile.sv
// ============================================================================
// Module      : tb_apb_slave_regfile
// Description : Self-checking bench for apb_slave_regfile. Two instances share
//               the clock and reset: one with no wait states, one with three.
//               Strobe checks are compiled in with APB_SLAVE_PSTRB_EN.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_apb_slave_regfile;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]        psel;
    logic [1:0]        penable;
    logic [1:0]        pwrite;
    logic [ADDR_W-1:0] paddr  [2];
    logic [DATA_W-1:0] pwdata [2];
    logic [DATA_W-1:0] prdata0;
    logic [DATA_W-1:0] prdata1;
    logic              pready0;
    logic              pready1;
    logic              pslverr0;
    logic              pslverr1;
`ifdef APB_SLAVE_PSTRB_EN
    logic [DATA_W/8-1:0] pstrb [2];
`endif

    int n_cmp = 0;
    int n_bad = 0;

    apb_slave_regfile #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .WAIT_CYCLES(0)
    ) dut0 (
        .Pclk(clk), .Preset(rst), .Paddr(paddr[0]), .Psel(psel[0]),
        .Penable(penable[0]), .Pwrite(pwrite[0]), .Pwdata(pwdata[0]),
`ifdef APB_SLAVE_PSTRB_EN
        .Pstrb(pstrb[0]),
`endif
        .Prdata(prdata0), .Pready(pready0), .Pslverr(pslverr0)
    );

    apb_slave_regfile #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .WAIT_CYCLES(3)
    ) dut3 (
        .Pclk(clk), .Preset(rst), .Paddr(paddr[1]), .Psel(psel[1]),
        .Penable(penable[1]), .Pwrite(pwrite[1]), .Pwdata(pwdata[1]),
`ifdef APB_SLAVE_PSTRB_EN
        .Pstrb(pstrb[1]),
`endif
        .Prdata(prdata1), .Pready(pready1), .Pslverr(pslverr1)
    );

    function automatic logic rdy(input int w);
        return (w == 0) ? pready0 : pready1;
    endfunction
    function automatic logic serr(input int w);
        return (w == 0) ? pslverr0 : pslverr1;
    endfunction
    function automatic logic [DATA_W-1:0] rdat(input int w);
        return (w == 0) ? prdata0 : prdata1;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One complete APB transfer; cyc counts setup as cycle 1
    task automatic xfer(input int w, input bit wr, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d,
                        output logic [DATA_W-1:0] rd, output logic er, output int cyc);
        bit done;
        done = 1'b0;
        rd   = '0;
        er   = 1'b0;
        @(posedge clk); #1;
        psel[w] = 1'b1; penable[w] = 1'b0; pwrite[w] = wr; paddr[w] = a; pwdata[w] = d;
        cyc = 1;
        @(negedge clk);
        check("setup_pready", 64'(rdy(w)), 64'd0);
        @(posedge clk); #1;
        penable[w] = 1'b1;
        cyc = 2;
        while (!done && cyc <= 20) begin
            @(negedge clk);
            if (rdy(w)) begin
                done = 1'b1;
                rd   = rdat(w);
                er   = serr(w);
            end else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        if (!done) check("pready_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        psel[w] = 1'b0; penable[w] = 1'b0;
    endtask

    typedef struct {
        int                w;
        bit                wr;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic [DATA_W-1:0] exp_rd;
        bit                exp_err;
        int                exp_cyc;
    } vec_t;

    vec_t vecs [16];

    initial begin
        logic [DATA_W-1:0] rd;
        logic              er;
        int                cyc;

        //          dut wr addr    wdata          exp_rdata      err cyc
        vecs[0]  = '{0, 1'b0, 8'h04, 32'h0,        32'h0,        1'b0, 2};
        vecs[1]  = '{0, 1'b1, 8'h08, 32'hDEADBEEF, 32'h0,        1'b0, 2};
        vecs[2]  = '{0, 1'b0, 8'h08, 32'h0,        32'hDEADBEEF, 1'b0, 2};
        vecs[3]  = '{0, 1'b1, 8'h00, 32'h12345678, 32'h0,        1'b0, 2};
        vecs[4]  = '{0, 1'b1, 8'h40, 32'hAAAA5555, 32'h0,        1'b1, 2};
        vecs[5]  = '{0, 1'b1, 8'h02, 32'h55555555, 32'h0,        1'b1, 2};
        vecs[6]  = '{0, 1'b0, 8'h00, 32'h0,        32'h12345678, 1'b0, 2};
        vecs[7]  = '{0, 1'b0, 8'h40, 32'h0,        32'h0,        1'b1, 2};
        vecs[8]  = '{0, 1'b1, 8'h3C, 32'hCAFEF00D, 32'h0,        1'b0, 2};
        vecs[9]  = '{0, 1'b0, 8'h3C, 32'h0,        32'hCAFEF00D, 1'b0, 2};
        vecs[10] = '{0, 1'b0, 8'h03, 32'h0,        32'h0,        1'b1, 2};
        vecs[11] = '{0, 1'b0, 8'hFC, 32'h0,        32'h0,        1'b1, 2};
        vecs[12] = '{1, 1'b1, 8'h0C, 32'h0BADF00D, 32'h0,        1'b0, 5};
        vecs[13] = '{1, 1'b0, 8'h0C, 32'h0,        32'h0BADF00D, 1'b0, 5};
        vecs[14] = '{1, 1'b0, 8'h44, 32'h0,        32'h0,        1'b1, 5};
        vecs[15] = '{1, 1'b0, 8'h08, 32'h0,        32'h0,        1'b0, 5};

        rst = 1'b1;
        psel = '0; penable = '0; pwrite = '0;
        for (int i = 0; i < 2; i++) begin
            paddr[i] = '0; pwdata[i] = '0;
`ifdef APB_SLAVE_PSTRB_EN
            pstrb[i] = '1;
`endif
        end

        // Reset state of both instances
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_pready0",  64'(pready0),  64'd0);
        check("rst_pslverr0", 64'(pslverr0), 64'd0);
        check("rst_prdata0",  64'(prdata0),  64'd0);
        check("rst_pready3",  64'(pready1),  64'd0);
        check("rst_prdata3",  64'(prdata1),  64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed vector table
        for (int i = 0; i < 16; i++) begin
            xfer(vecs[i].w, vecs[i].wr, vecs[i].a, vecs[i].d, rd, er, cyc);
            check($sformatf("vec%0d_rdata", i),   64'(rd),  64'(vecs[i].exp_rd));
            check($sformatf("vec%0d_pslverr", i), 64'(er),  64'(vecs[i].exp_err));
            check($sformatf("vec%0d_latency", i), 64'(cyc), 64'(vecs[i].exp_cyc));
        end

        // Erroring writes above must not have disturbed word 0
        xfer(0, 1'b0, 8'h00, 32'h0, rd, er, cyc);
        check("word0_after_err", 64'(rd), 64'h12345678);

        // Idle bus: read data stays zero outside the Pready cycle
        @(negedge clk);
        check("idle_prdata", 64'(prdata0), 64'd0);

        // Master drops Psel during the wait states: no write, back to IDLE
        @(posedge clk); #1;
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
        paddr[1] = 8'h10; pwdata[1] = 32'h11112222;
        @(posedge clk); #1;
        penable[1] = 1'b1;
        @(posedge clk); #1;
        psel[1] = 1'b0; penable[1] = 1'b0;
        @(negedge clk);
        check("abort_pready", 64'(pready1), 64'd0);
        xfer(1, 1'b0, 8'h10, 32'h0, rd, er, cyc);
        check("abort_nowrite", 64'(rd),  64'd0);
        check("abort_latency", 64'(cyc), 64'd5);

        // Reset lands on the completing cycle of a write: dropped, mem cleared
        @(posedge clk); #1;
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
        paddr[1] = 8'h0C; pwdata[1] = 32'h77778888;
        @(posedge clk); #1;
        penable[1] = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_pready",  64'(pready1),  64'd0);
        check("rst_mid_pslverr", 64'(pslverr1), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        psel[1] = 1'b0; penable[1] = 1'b0;
        xfer(1, 1'b0, 8'h0C, 32'h0, rd, er, cyc);
        check("rst_mid_cleared", 64'(rd), 64'd0);
        xfer(0, 1'b0, 8'h08, 32'h0, rd, er, cyc);
        check("rst_cleared_dut0", 64'(rd), 64'd0);

`ifdef APB_SLAVE_PSTRB_EN
        // Byte strobes: only lanes 0 and 2 take the zero write
        pstrb[0] = 4'b1111;
        xfer(0, 1'b1, 8'h10, 32'hFFFFFFFF, rd, er, cyc);
        pstrb[0] = 4'b0101;
        xfer(0, 1'b1, 8'h10, 32'h00000000, rd, er, cyc);
        check("strb_err", 64'(er), 64'd0);
        pstrb[0] = 4'b0000;
        xfer(0, 1'b1, 8'h10, 32'h12345678, rd, er, cyc);
        check("strb0_err", 64'(er), 64'd0);
        pstrb[0] = 4'b0000;
        xfer(0, 1'b0, 8'h10, 32'h0, rd, er, cyc);
        check("strb_readback", 64'(rd), 64'hFF00FF00);
        pstrb[0] = 4'b1111;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
